// File: rtl/pmem_write_buffer.sv
// Posted-write buffer in front of the pmem DPI write wrapper: a small circular
// FIFO of word-aligned byte-masked writes that can merge into its tail entry.
module pmem_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MERGE_EN = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_W-1:0]          in_addr_i,
    input  logic [DATA_W/8-1:0]        in_strb_i,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ADDR_W-1:0]          out_addr_o,
    output logic [DATA_W/8-1:0]        out_strb_o,
    output logic [DATA_W-1:0]          out_data_o,
    input  logic                       flush_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(STRB_W - 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [STRB_W-1:0] r_strb [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_flush_pending;

    logic [PTR_W-1:0]  w_last;
    logic [ADDR_W-1:0] w_word_addr;
    logic [DATA_W-1:0] w_lane_mask;
    logic              w_pop;
    logic              w_merge_hit;
    logic              w_full;
    logic              w_push;
    logic              w_push_data;
    logic              w_write_new;
    logic              w_merge;
    logic [CNT_W-1:0]  w_count_next;

    assign w_last      = r_tail - PTR_W'(1);
    assign w_word_addr = in_addr_i & ADDR_MASK;
    assign w_pop       = (r_count != '0) & out_ready_i;
    // A lone entry leaving this cycle cannot absorb a merge; the write becomes a new entry.
    assign w_merge_hit = (MERGE_EN != 0) && (r_count != '0) &&
                         (r_addr[w_last] == w_word_addr) &&
                         !((r_count == CNT_W'(1)) && w_pop);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign in_ready_o  = !r_flush_pending & (!w_full | w_merge_hit);
    assign w_push      = in_valid_i & in_ready_o;
    assign w_push_data = w_push & (|in_strb_i);
    assign w_write_new = w_push_data & !w_merge_hit;
    assign w_merge     = w_push_data & w_merge_hit;
    assign w_count_next = r_count + CNT_W'(w_write_new) - CNT_W'(w_pop);

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign w_lane_mask[gi*8 +: 8] = {8{in_strb_i[gi]}};
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_addr[gi] <= '0;
                    r_strb[gi] <= '0;
                    r_data[gi] <= '0;
                end else if (w_write_new && (r_tail == PTR_W'(gi))) begin
                    r_addr[gi] <= w_word_addr;
                    r_strb[gi] <= in_strb_i;
                    r_data[gi] <= in_data_i & w_lane_mask;
                end else if (w_merge && (w_last == PTR_W'(gi))) begin
                    r_strb[gi] <= r_strb[gi] | in_strb_i;
                    r_data[gi] <= (r_data[gi] & ~w_lane_mask) | (in_data_i & w_lane_mask);
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            if (w_write_new) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)       r_head <= r_head + PTR_W'(1);
            r_count         <= w_count_next;
            r_flush_pending <= (r_flush_pending | (flush_i & (r_count != '0))) &
                               (w_count_next != '0);
        end
    end

    assign out_valid_o = (r_count != '0);
    assign out_addr_o  = r_addr[r_head];
    assign out_strb_o  = r_strb[r_head];
    assign out_data_o  = r_data[r_head];
    assign busy_o      = (r_count != '0) | r_flush_pending;
    assign count_o     = r_count;
endmodule

// File: tb/tb_pmem_write_buffer.sv
// Bench for pmem_write_buffer: vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_pmem_write_buffer;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_addr_i = '0;
    logic [3:0]  in_strb_i = '0;
    logic [31:0] in_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_addr_o;
    logic [3:0]  out_strb_o;
    logic [31:0] out_data_o;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic [2:0]  count_o;

    pmem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .MERGE_EN(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_addr_i(in_addr_i), .in_strb_i(in_strb_i), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_strb_o(out_strb_o), .out_data_o(out_data_o),
        .flush_i(flush_i), .busy_o(busy_o), .count_o(count_o)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        ordy;
        logic        ev;
        logic [2:0]  ecnt;
        logic [31:0] eaddr;
        logic [3:0]  estrb;
        logic [31:0] edata;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } ent_t;

    vec_t tbl [9];
    ent_t q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic ordy, input logic fl);
        in_valid_i  = v;
        in_addr_i   = a;
        in_strb_i   = s;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        drive(1'b1, a, s, d, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    initial begin
        tbl[0] = '{1'b1, 32'h80000003, 4'h1, 32'h000000AA, 1'b0, 1'b1, 3'd1, 32'h80000000, 4'h1, 32'h000000AA};
        tbl[1] = '{1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 3'd0, 32'h0,        4'h0, 32'h0};
        tbl[2] = '{1'b1, 32'h80000000, 4'h3, 32'h00001122, 1'b0, 1'b1, 3'd1, 32'h80000000, 4'h3, 32'h00001122};
        tbl[3] = '{1'b1, 32'h80000002, 4'hC, 32'h33440000, 1'b0, 1'b1, 3'd1, 32'h80000000, 4'hF, 32'h33441122};
        tbl[4] = '{1'b1, 32'h80000004, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 3'd2, 32'h80000000, 4'hF, 32'h33441122};
        tbl[5] = '{1'b1, 32'h80000007, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 3'd2, 32'h80000000, 4'hF, 32'h33441122};
        tbl[6] = '{1'b1, 32'h80000008, 4'h1, 32'h00000055, 1'b1, 1'b1, 3'd2, 32'h80000004, 4'hF, 32'hDEADBEEF};
        tbl[7] = '{1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1, 3'd1, 32'h80000008, 4'h1, 32'h00000055};
        tbl[8] = '{1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 3'd0, 32'h0,        4'h0, 32'h0};

        // Reset state
        do_reset();
        idle();
        $display("[TB] reset check");
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_count", count_o, 3'd0);
        chk("rst_ready", in_ready_o, 1'b1);
        chk("rst_addr", out_addr_o, 32'h0);
        chk("rst_strb", out_strb_o, 4'h0);
        chk("rst_data", out_data_o, 32'h0);

        // Vector table: single write, merge, zero-strobe discard, push+pop
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].ordy, 1'b0);
            tick();
            idle();
            $display("[TB] vec %0d v=%0b a=%h s=%h d=%h ordy=%0b -> cnt=%0d", i,
                     tbl[i].v, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].ordy, count_o);
            chk($sformatf("vec%0d_valid", i), out_valid_o, tbl[i].ev);
            chk($sformatf("vec%0d_count", i), count_o, tbl[i].ecnt);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_addr", i), out_addr_o, tbl[i].eaddr);
                chk($sformatf("vec%0d_strb", i), out_strb_o, tbl[i].estrb);
                chk($sformatf("vec%0d_data", i), out_data_o, tbl[i].edata);
            end
        end

        // Full, then a merge into the tail word is still accepted
        do_reset();
        push(32'h200, 4'h3, 32'h0000AAAA);
        push(32'h204, 4'h3, 32'h0000BBBB);
        push(32'h208, 4'h3, 32'h0000CCCC);
        push(32'h20C, 4'h3, 32'h00001234);
        drive(1'b1, 32'h300, 4'hF, 32'h0, 1'b0, 1'b0);
        $display("[TB] full: 4 pushes, cnt=%0d ready=%0b", count_o, in_ready_o);
        chk("full_count", count_o, 3'd4);
        chk("full_ready", in_ready_o, 1'b0);
        drive(1'b1, 32'h20E, 4'h4, 32'h00770000, 1'b0, 1'b0);
        chk("full_merge_ready", in_ready_o, 1'b1);
        tick();
        idle();
        chk("full_merge_count", count_o, 3'd4);
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        idle();
        $display("[TB] full: drained to tail entry a=%h s=%h d=%h", out_addr_o, out_strb_o, out_data_o);
        chk("full_tail_addr", out_addr_o, 32'h20C);
        chk("full_tail_strb", out_strb_o, 4'h7);
        chk("full_tail_data", out_data_o, 32'h00771234);

        // Flush: ready held low until drained
        do_reset();
        push(32'h400, 4'hF, 32'h1);
        push(32'h404, 4'hF, 32'h2);
        push(32'h408, 4'hF, 32'h3);
        drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500, 4'hF, 32'h9, 1'b1, 1'b0);
            $display("[TB] flush cycle %0d cnt=%0d ready=%0b", i, count_o, in_ready_o);
            chk($sformatf("flush_ready%0d", i), in_ready_o, 1'b0);
            chk($sformatf("flush_busy%0d", i), busy_o, 1'b1);
            tick();
        end
        idle();
        chk("flush_done_count", count_o, 3'd0);
        chk("flush_done_busy", busy_o, 1'b0);
        chk("flush_done_ready", in_ready_o, 1'b1);

        // Reset mid-stream drops entries
        do_reset();
        push(32'h600, 4'hF, 32'h6);
        push(32'h604, 4'hF, 32'h7);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        idle();
        $display("[TB] mid-stream reset cnt=%0d valid=%0b", count_o, out_valid_o);
        chk("midrst_valid", out_valid_o, 1'b0);
        chk("midrst_count", count_o, 3'd0);
        chk("midrst_addr", out_addr_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
            chk($sformatf("midrst_no_hs%0d", i), out_valid_o, 1'b0);
            tick();
        end

        // Count-1 race: same-word push while the lone entry pops
        do_reset();
        push(32'h100, 4'hF, 32'h11111111);
        drive(1'b1, 32'h100, 4'h1, 32'h00000022, 1'b1, 1'b0);
        chk("race_ready", in_ready_o, 1'b1);
        tick();
        idle();
        $display("[TB] race: cnt=%0d a=%h s=%h d=%h", count_o, out_addr_o, out_strb_o, out_data_o);
        chk("race_count", count_o, 3'd1);
        chk("race_addr", out_addr_o, 32'h100);
        chk("race_strb", out_strb_o, 4'h1);
        chk("race_data", out_data_o, 32'h00000022);

        // Randomized run against a queue model
        begin
            bit fp;
            fp = 1'b0;
            do_reset();
            q.delete();
            for (int cyc = 0; cyc < 400; cyc++) begin
                logic        v, ordy, fl, pop, mh, rdy;
                logic [31:0] a, d, wa, m;
                logic [3:0]  s;
                int          size;
                ent_t        e;
                v    = ($urandom_range(0, 3) != 0);
                a    = 32'h1000 + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 3));
                s    = 4'($urandom_range(0, 15));
                d    = $urandom;
                ordy = ($urandom_range(0, 2) == 0);
                fl   = ($urandom_range(0, 30) == 0);
                drive(v, a, s, d, ordy, fl);

                size = q.size();
                wa   = a & ~32'h3;
                m    = lane_mask(s);
                pop  = (size != 0) && ordy;
                mh   = 1'b0;
                if (size != 0) mh = (q[size-1].a == wa) && !(size == 1 && pop);
                rdy  = !fp && ((size < DEPTH) || mh);

                chk("rnd_ready", in_ready_o, rdy);
                chk("rnd_valid", out_valid_o, size != 0);
                chk("rnd_count", count_o, 64'(size));
                chk("rnd_busy", busy_o, (size != 0) || fp);
                if (size != 0) begin
                    chk("rnd_addr", out_addr_o, q[0].a);
                    chk("rnd_strb", out_strb_o, q[0].s);
                    chk("rnd_data", out_data_o & lane_mask(q[0].s), q[0].d & lane_mask(q[0].s));
                end
                tick();

                if (v && rdy && (s != 4'h0)) begin
                    $display("[TB] rnd push a=%h s=%h d=%h merge=%0b", a, s, d, mh);
                    if (mh) begin
                        e = q[size-1];
                        e.s = e.s | s;
                        e.d = (e.d & ~m) | (d & m);
                        q[size-1] = e;
                    end else begin
                        q.push_back('{wa, s, d & m});
                    end
                end
                if (pop) void'(q.pop_front());
                fp = (fp || (fl && size != 0)) && (q.size() != 0);
            end
            idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
